fibo_seq_engine: RTL

Parametrised recurrence-sequence generator and the next-generation Fibonacci counter. Selectable recurrence: Fibonacci, Pell or Tribonacci. Terms stream out one per cycle under a valid/ready handshake, with sticky overflow detection, an abort input and a done pulse. Sits beside the controller/datapath counters as a reusable sequence source for downstream accumulators.

---
 rtl/fibo_seq_engine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fibo_seq_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fibo_seq_engine
//  Description : Recurrence-sequence generator (Fibonacci / Pell / Tribonacci)
//                that streams one term per cycle over a valid/ready handshake.
//                It provides sticky overflow detection, a synchronous abort
//                and a one-cycle done pulse.
//  Build macro : FIBO_SAT_EN - when defined, overflowing terms saturate to
//                all-ones. When undefined, they wrap to the low R_SIZE bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module fibo_seq_engine #(
  parameter int R_SIZE = 16,
  parameter int C_SIZE = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [R_SIZE-1:0] data1,
  input  logic [R_SIZE-1:0] data2,
  input  logic [R_SIZE-1:0] data3,
  input  logic [C_SIZE-1:0] count,
  output logic              ready,
  output logic [R_SIZE-1:0] term,
  output logic              term_valid,
  input  logic              term_ready,
  output logic [R_SIZE-1:0] result,
  output logic              overflow,
  output logic              done
);

  // One-hot state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  localparam logic [1:0]        c_mode_pell = 2'd1;
  localparam logic [1:0]        c_mode_trib = 2'd2;
  localparam logic [C_SIZE-1:0] c_cnt_one   = {{(C_SIZE-1){1'b0}}, 1'b1};
`ifdef FIBO_SAT_EN
  localparam logic [R_SIZE-1:0] c_all_ones  = {R_SIZE{1'b1}};
`endif

  state_t              state_q, state_d;
  logic [R_SIZE-1:0]   a_q, a_d;
  logic [R_SIZE-1:0]   b_q, b_d;
  logic [R_SIZE-1:0]   t_q, t_d;
  logic [C_SIZE-1:0]   c_q, c_d;
  logic [1:0]          mode_q, mode_d;
  logic                ovf_q, ovf_d;

  logic [R_SIZE+1:0]   w_next_full;
  logic                w_next_ovf;
  logic [R_SIZE-1:0]   w_next_term;
  logic                w_has_term;
  logic                w_offer;
  logic                w_xfer;
  logic                w_load;

  // Next term at two guard bits of headroom: A+2B and A+B+T both fit R_SIZE+2
  always_comb begin
    w_next_full = '0;
    case (mode_q)
      c_mode_pell: w_next_full = {2'b00, a_q} + {1'b0, b_q, 1'b0};
      c_mode_trib: w_next_full = {2'b00, a_q} + {2'b00, b_q} + {2'b00, t_q};
      default:     w_next_full = {2'b00, a_q} + {2'b00, b_q};
    endcase
  end

  assign w_next_ovf = |w_next_full[R_SIZE+1:R_SIZE];

`ifdef FIBO_SAT_EN
  assign w_next_term = w_next_ovf ? c_all_ones : w_next_full[R_SIZE-1:0];
`else
  assign w_next_term = w_next_full[R_SIZE-1:0];
`endif

  // Handshake qualifiers. Abort suppresses the offer, so it always wins over term_ready.
  assign w_has_term = (c_q != '0);
  assign w_offer    = (state_q == ST_RUN) && !abort && w_has_term;
  assign w_xfer     = w_offer && term_ready;
  assign w_load     = (state_q == ST_IDLE) && start;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    done       = 1'b0;
    term_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        term_valid = w_offer;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!w_has_term) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: load on accepted start, shift the window on a transfer
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    t_d    = t_q;
    c_d    = c_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    if (w_load) begin
      a_d    = data1;
      b_d    = data2;
      t_d    = data3;
      c_d    = count;
      mode_d = mode;
      ovf_d  = 1'b0;
    end else if (w_xfer) begin
      a_d = b_q;
      c_d = c_q - c_cnt_one;
      if (mode_q == c_mode_trib) begin
        b_d = t_q;
        t_d = w_next_term;
      end else begin
        b_d = w_next_term;
      end
      if (w_next_ovf) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      t_q    <= '0;
      c_q    <= '0;
      mode_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      t_q    <= t_d;
      c_q    <= c_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  // The newest term lives in T for Tribonacci and in B otherwise
  always_comb begin
    term     = w_next_term;
    overflow = ovf_q;
    result   = (mode_q == c_mode_trib) ? t_q : b_q;
  end

endmodule
`default_nettype wire
